// File: rtl/sdram_port_arbiter.sv
// Shares one toggle-handshake SDRAM port between the Oric CPU RAM bus and a byte-wide loader.
// CPU bus strobes become single SDRAM transactions; loader writes fill the idle gaps, CPU always first.
module sdram_port_arbiter #(
    parameter int         ADDR_W = 16,
    parameter logic [1:0] ROM_HI = 2'b11
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              cpu_cs,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_busy,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_a,
    input  logic [7:0]        ld_d,
    output logic              ld_ack,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        mem_ds,
    output logic              mem_we,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q
);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_CPU, S_LD} state_t;

    state_t            r_state;
    logic              r_oe_d;
    logic              r_we_d;
    logic [ADDR_W-1:0] r_a_d;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_a;
    logic [7:0]        r_pend_d;
    logic              r_pend_we;
    logic [7:0]        r_cpu_q;
    logic              r_ld_ack;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_a;
    logic [1:0]        r_mem_ds;
    logic              r_mem_we;
    logic [15:0]       r_mem_d;

    logic              w_cpu_sel;
    logic              w_cpu_evt;
    logic              w_acked;
    logic [ADDR_W-1:0] w_iss_a;
    logic [7:0]        w_iss_d;
    logic              w_iss_we;

    assign w_cpu_sel = cpu_cs && (cpu_a[ADDR_W-1 -: 2] != ROM_HI);
    assign w_cpu_evt = w_cpu_sel && ((cpu_oe && !r_oe_d) ||
                                     (cpu_we && !r_we_d) ||
                                     (cpu_oe && (cpu_a != r_a_d)));
    assign w_acked   = (mem_ack == r_mem_req);

    // A fresh event bypasses the pending slot so an idle port issues on the very next edge.
    assign w_iss_a   = w_cpu_evt ? cpu_a  : r_pend_a;
    assign w_iss_d   = w_cpu_evt ? cpu_d  : r_pend_d;
    assign w_iss_we  = w_cpu_evt ? cpu_we : r_pend_we;

    assign cpu_q    = w_cpu_sel ? r_cpu_q : 8'h00;
    assign cpu_busy = r_pend || (r_state == S_CPU);
    assign ld_ack   = r_ld_ack;
    assign mem_req  = r_mem_req;
    assign mem_a    = r_mem_a;
    assign mem_ds   = r_mem_ds;
    assign mem_we   = r_mem_we;
    assign mem_d    = r_mem_d;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state   <= S_SYNC;
            r_oe_d    <= 1'b0;
            r_we_d    <= 1'b0;
            r_a_d     <= '0;
            r_pend    <= 1'b0;
            r_pend_a  <= '0;
            r_pend_d  <= 8'h00;
            r_pend_we <= 1'b0;
            r_cpu_q   <= 8'h00;
            r_ld_ack  <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_a   <= '0;
            r_mem_ds  <= 2'b00;
            r_mem_we  <= 1'b0;
            r_mem_d   <= 16'h0000;
        end else begin
            r_oe_d   <= cpu_oe;
            r_we_d   <= cpu_we;
            r_a_d    <= cpu_a;
            r_ld_ack <= 1'b0;

            if (w_cpu_evt) begin
                r_pend    <= 1'b1;
                r_pend_a  <= cpu_a;
                r_pend_d  <= cpu_d;
                r_pend_we <= cpu_we;
            end

            case (r_state)
                S_SYNC: begin
                    if (w_acked) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_cpu_evt || r_pend) begin
                        r_mem_req <= ~r_mem_req;
                        r_mem_a   <= w_iss_a;
                        r_mem_we  <= w_iss_we;
                        r_mem_ds  <= w_iss_we ? {w_iss_a[0], ~w_iss_a[0]} : 2'b11;
                        r_mem_d   <= {w_iss_d, w_iss_d};
                        // NOTE: later non-blocking write wins, so this clear overrides the latch above.
                        r_pend    <= 1'b0;
                        r_state   <= S_CPU;
                    end else if (ld_req) begin
                        r_mem_req <= ~r_mem_req;
                        r_mem_a   <= ld_a;
                        r_mem_we  <= 1'b1;
                        r_mem_ds  <= {ld_a[0], ~ld_a[0]};
                        r_mem_d   <= {ld_d, ld_d};
                        r_state   <= S_LD;
                    end
                end
                S_CPU: begin
                    if (w_acked) begin
                        if (!r_mem_we) r_cpu_q <= r_mem_a[0] ? mem_q[15:8] : mem_q[7:0];
                        r_state <= S_IDLE;
                    end
                end
                S_LD: begin
                    if (w_acked) begin
                        r_ld_ack <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: toggle-handshake SDRAM model, byte-level reference memory,
// table-driven CPU vectors, directed corner sequences and randomized CPU/loader traffic.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        init_n;
    logic        cpu_cs, cpu_oe, cpu_we;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_busy;
    logic        ld_req;
    logic [15:0] ld_a;
    logic [7:0]  ld_d;
    logic        ld_ack;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_a;
    logic [1:0]  mem_ds;
    logic        mem_we;
    logic [15:0] mem_d;
    logic [15:0] mem_q = 16'h0000;

    sdram_port_arbiter #(.ADDR_W(16), .ROM_HI(2'b11)) dut (
        .clk      (clk),
        .init_n   (init_n),
        .cpu_cs   (cpu_cs),
        .cpu_oe   (cpu_oe),
        .cpu_we   (cpu_we),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_q    (cpu_q),
        .cpu_busy (cpu_busy),
        .ld_req   (ld_req),
        .ld_a     (ld_a),
        .ld_d     (ld_d),
        .ld_ack   (ld_ack),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_a    (mem_a),
        .mem_ds   (mem_ds),
        .mem_we   (mem_we),
        .mem_d    (mem_d),
        .mem_q    (mem_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [1:0] r;
        logic [5:0] lo;
        r  = 2'($urandom_range(0, 3));
        lo = 6'($urandom_range(0, 63));
        return {r, 8'h00, lo};
    endfunction

    // Reference: plain byte-addressed memory updated in the order the arbiter must serve requests.
    logic [7:0]  ref_mem [0:65535];
    // SDRAM model storage: 16-bit words with byte lanes.
    logic [15:0] sd_mem  [0:32767];

    typedef struct packed {
        logic [15:0] a;
        logic [1:0]  ds;
        logic        we;
        logic [15:0] d;
    } req_t;

    req_t log_q[$];
    req_t sd_cur;
    logic sd_busy  = 1'b0;
    int   sd_cnt   = 0;
    int   fix_lat  = 4;
    logic rand_lat = 1'b0;
    int   ld_ack_cnt = 0;

    always @(negedge clk) begin
        logic [15:0] w;
        if (sd_busy) begin
            if (sd_cnt == 0) begin
                if (sd_cur.we) begin
                    w = sd_mem[sd_cur.a[15:1]];
                    if (sd_cur.ds[0]) w[7:0]  = sd_cur.d[7:0];
                    if (sd_cur.ds[1]) w[15:8] = sd_cur.d[15:8];
                    sd_mem[sd_cur.a[15:1]] = w;
                end else begin
                    mem_q = sd_mem[sd_cur.a[15:1]];
                end
                mem_ack = ~mem_ack;
                sd_busy = 1'b0;
            end else begin
                sd_cnt--;
            end
        end else if (mem_req !== mem_ack) begin
            sd_cur  = '{a: mem_a, ds: mem_ds, we: mem_we, d: mem_d};
            log_q.push_back(sd_cur);
            sd_busy = 1'b1;
            sd_cnt  = rand_lat ? int'($urandom_range(0, 5)) : fix_lat;
        end
    end

    always @(negedge clk) if (ld_ack) ld_ack_cnt++;

    // A new request may only be raised once the previous one has been acknowledged.
    logic mon_req = 1'b0, mon_ack = 1'b0, mon_ok = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mon_ok && init_n && (mem_req !== mon_req))
            check("request raised while previous outstanding", 32'(mon_ack), 32'(mon_req));
        mon_req = mem_req;
        mon_ack = mem_ack;
        mon_ok  = init_n;
    end

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (cpu_busy && cyc < 100);
        check({tag, " idle"}, 32'(cpu_busy), 32'd0);
    endtask

    task automatic run_op(input logic cpu_en, input logic cpu_wr, input logic [15:0] ca,
                          input logic [7:0] cd, input logic ld_en, input logic [15:0] la,
                          input logic [7:0] ldd, input int exp_n, input logic [7:0] exp_q,
                          input string tag);
        int   n0, cyc;
        logic ld_done;
        n0      = log_q.size();
        ld_done = !ld_en;
        @(negedge clk);
        cpu_cs = cpu_en; cpu_a = ca; cpu_d = cd;
        cpu_oe = cpu_en && !cpu_wr;
        cpu_we = cpu_en && cpu_wr;
        ld_req = ld_en; ld_a = la; ld_d = ldd;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (ld_ack) begin
                ld_req  = 1'b0;
                ld_done = 1'b1;
            end
        end while ((cpu_busy || !ld_done) && cyc < 200);
        check({tag, " completion"}, {30'd0, cpu_busy, ld_done}, 32'd1);
        if (cpu_en && !cpu_wr) check({tag, " cpu_q"}, 32'(cpu_q), 32'(exp_q));
        check({tag, " request count"}, log_q.size() - n0, exp_n);
        if (cpu_en && cpu_wr && (ca[15:14] != 2'b11)) ref_mem[ca] = cd;
        if (ld_en) ref_mem[la] = ldd;
        @(negedge clk);
        cpu_oe = 1'b0; cpu_we = 1'b0; cpu_cs = 1'b0; ld_req = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        int          exp_n;
        logic [1:0]  exp_ds;
        logic [15:0] exp_md;
        logic [7:0]  exp_q;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic r0, r1, stall_ok, cpu_en, cpu_wr, ld_en;
        int   n, a0, cyc, kind, exp_n;
        logic [15:0] ca, la;
        logic [7:0]  cd, ldd, eq;

        vecs[0] = '{1'b0, 16'h1235, 8'h00, 1, 2'b11, 16'h0000, 8'hAB};
        vecs[1] = '{1'b1, 16'h0400, 8'h5A, 1, 2'b01, 16'h5A5A, 8'h00};
        vecs[2] = '{1'b0, 16'h0400, 8'h00, 1, 2'b11, 16'h0000, 8'h5A};
        vecs[3] = '{1'b1, 16'h0401, 8'hC3, 1, 2'b10, 16'hC3C3, 8'h00};
        vecs[4] = '{1'b0, 16'h0401, 8'h00, 1, 2'b11, 16'h0000, 8'hC3};
        vecs[5] = '{1'b0, 16'h0400, 8'h00, 1, 2'b11, 16'h0000, 8'h5A};
        vecs[6] = '{1'b0, 16'hC000, 8'h00, 0, 2'b00, 16'h0000, 8'h00};
        vecs[7] = '{1'b1, 16'hC001, 8'h77, 0, 2'b00, 16'h0000, 8'h00};
        vecs[8] = '{1'b0, 16'hBFFF, 8'h00, 1, 2'b11, 16'h0000, init_byte(16'hBFFF)};
        vecs[9] = '{1'b0, 16'h3FFF, 8'h00, 1, 2'b11, 16'h0000, init_byte(16'h3FFF)};

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
        ref_mem[16'h1234] = 8'h12;
        ref_mem[16'h1235] = 8'hAB;
        for (int i = 0; i < 32768; i++) sd_mem[i] = {ref_mem[2*i+1], ref_mem[2*i]};

        init_n = 1'b0;
        cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0; cpu_a = 16'h0000; cpu_d = 8'h00;
        ld_req = 1'b0; ld_a = 16'h0000; ld_d = 8'h00;

        repeat (3) @(negedge clk);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset cpu_q", 32'(cpu_q), 32'd0);
        check("reset ld_ack", 32'(ld_ack), 32'd0);
        check("reset cpu_busy", 32'(cpu_busy), 32'd0);
        init_n = 1'b1;
        repeat (3) @(negedge clk);

        // Issue latency, ack-to-result latency and earliest back-to-back reissue.
        fix_lat = 4;
        r0 = mem_req;
        r1 = ~r0;
        @(negedge clk);
        cpu_cs = 1'b1; cpu_a = 16'h0002; cpu_oe = 1'b1;
        @(posedge clk); #1;
        check("issue one cycle after event", 32'(mem_req), 32'(r1));
        check("busy after issue", 32'(cpu_busy), 32'd1);
        cyc = 0;
        while (mem_ack !== mem_req && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("busy clears cycle after ack", 32'(cpu_busy), 32'd0);
        check("cpu_q updated cycle after ack", 32'(cpu_q), 32'(ref_mem[16'h0002]));
        r0 = mem_req;
        r1 = ~r0;
        @(negedge clk);
        cpu_a = 16'h0003;
        @(posedge clk); #1;
        check("back-to-back reissue", 32'(mem_req), 32'(r1));
        wait_idle("back-to-back");
        check("back-to-back cpu_q", 32'(cpu_q), 32'(ref_mem[16'h0003]));
        @(negedge clk);
        cpu_oe = 1'b0; cpu_cs = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(1'b1, vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0, 16'h0000, 8'h00,
                   vecs[i].exp_n, vecs[i].exp_q, $sformatf("vec%0d", i));
            if (vecs[i].exp_n == 1) begin
                check($sformatf("vec%0d mem_a", i), 32'(log_q[$].a), 32'(vecs[i].a));
                check($sformatf("vec%0d mem_ds", i), 32'(log_q[$].ds), 32'(vecs[i].exp_ds));
                check($sformatf("vec%0d mem_we", i), 32'(log_q[$].we), 32'(vecs[i].wr));
                if (vecs[i].wr)
                    check($sformatf("vec%0d mem_d", i), 32'(log_q[$].d), 32'(vecs[i].exp_md));
            end
        end

        // Contention: loader and CPU read arrive together; CPU goes first.
        a0 = ld_ack_cnt;
        run_op(1'b1, 1'b0, 16'h1235, 8'h00, 1'b1, 16'hC100, 8'h77, 2, 8'hAB, "contention");
        n = log_q.size();
        check("contention first is cpu", 32'(log_q[n-2].a), 32'h1235);
        check("contention first is read", 32'(log_q[n-2].we), 32'd0);
        check("contention second is loader", 32'(log_q[n-1].a), 32'hC100);
        check("contention loader ds", 32'(log_q[n-1].ds), 32'h1);
        check("contention loader data", 32'(log_q[n-1].d), 32'h7777);
        repeat (4) @(negedge clk);
        check("contention single ld_ack", ld_ack_cnt - a0, 32'd1);
        check("contention no extra requests", log_q.size(), n);
        check("loader byte stored", 32'(sd_mem[15'h6080][7:0]), 32'h77);

        // Address change with oe held: one request per distinct address.
        n = log_q.size();
        @(negedge clk);
        cpu_cs = 1'b1; cpu_a = 16'h0010; cpu_oe = 1'b1;
        wait_idle("addr 0010");
        check("addr 0010 cpu_q", 32'(cpu_q), 32'(ref_mem[16'h0010]));
        @(negedge clk); cpu_a = 16'h0011;
        wait_idle("addr 0011");
        check("addr 0011 cpu_q", 32'(cpu_q), 32'(ref_mem[16'h0011]));
        @(negedge clk); cpu_a = 16'h0012;
        wait_idle("addr 0012");
        check("addr 0012 cpu_q", 32'(cpu_q), 32'(ref_mem[16'h0012]));
        repeat (5) @(negedge clk);
        check("addr change request count", log_q.size() - n, 32'd3);
        cpu_cs = 1'b0;
        #1;
        check("cpu_q zero when deselected", 32'(cpu_q), 32'd0);
        @(negedge clk); cpu_oe = 1'b0;

        // Reset mid-op: arrange mem_req=1 so the issue drops it to 0 and reset leaves ack!=req.
        if (mem_req !== 1'b1)
            run_op(1'b1, 1'b0, 16'h0005, 8'h00, 1'b0, 16'h0000, 8'h00, 1, ref_mem[16'h0005], "align");
        fix_lat = 8;
        @(negedge clk);
        cpu_cs = 1'b1; cpu_a = 16'h2000; cpu_d = 8'h11; cpu_we = 1'b1;
        @(posedge clk); #1;
        check("mid-op write issued", 32'(mem_req), 32'd0);
        @(negedge clk);
        init_n = 1'b0; cpu_we = 1'b0; cpu_cs = 1'b0;
        #1;
        check("async reset cpu_busy", 32'(cpu_busy), 32'd0);
        check("async reset mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        cpu_cs = 1'b1; cpu_a = 16'h1235; cpu_oe = 1'b1;
        ref_mem[16'h2000] = 8'h11;
        stall_ok = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (mem_ack !== 1'b0 && mem_req !== 1'b0) stall_ok = 1'b0;
        end while (mem_ack !== 1'b0 && cyc < 100);
        check("no issue while ack in flight", 32'(stall_ok), 32'd1);
        wait_idle("after sync");
        check("post-reset read cpu_q", 32'(cpu_q), 32'hAB);
        check("post-reset read addr", 32'(log_q[$].a), 32'h1235);
        @(negedge clk);
        cpu_oe = 1'b0; cpu_cs = 1'b0;
        fix_lat = 4;

        rand_lat = 1'b1;
        for (int k = 0; k < 150; k++) begin
            kind   = int'($urandom_range(0, 3));
            ca     = rand_addr();
            la     = rand_addr();
            cd     = 8'($urandom);
            ldd    = 8'($urandom);
            cpu_en = (kind != 2);
            cpu_wr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            ld_en  = (kind >= 2);
            exp_n  = ((cpu_en && ca[15:14] != 2'b11) ? 1 : 0) + (ld_en ? 1 : 0);
            eq     = (ca[15:14] == 2'b11) ? 8'h00 : ref_mem[ca];
            run_op(cpu_en, cpu_wr, ca, cd, ld_en, la, ldd, exp_n, eq, $sformatf("rand%0d", k));
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
